// File: rtl/maze_lookup_arbiter.sv
// Purpose: round-robin share of the maze map read port among the movers; also paces them with a move tick.
// Latency: in-bounds lookup RD_LAT+2 cycles from the grant edge to resp_valid_o; out-of-bounds lookup 1 cycle.
// Backpressure: one lookup in flight; requesters hold req_i until their resp_valid_o bit. Optional macro: PACMAN_PRIORITY_EN.
module maze_lookup_arbiter #(
   parameter int NUM_REQ  = 5,
   parameter int XOFFSET  = 24,
   parameter int YOFFSET  = 130,
   parameter int MAP_W    = 380,
   parameter int MAP_H    = 432,
   parameter int RD_LAT   = 1,
   parameter int TICK_DIV = 1000000
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_REQ-1:0]      req_i,
   input  logic [10*NUM_REQ-1:0]   req_x_i,
   input  logic [10*NUM_REQ-1:0]   req_y_i,
   output logic                    map_rd_en_o,
   output logic [9:0]              map_col_o,
   output logic [9:0]              map_row_o,
   input  logic [3:0]              map_data_i,
   output logic [NUM_REQ-1:0]      resp_valid_o,
   output logic [3:0]              resp_dirs_o,
   output logic                    resp_oob_o,
   output logic                    move_tick_o,
   output logic                    tick_overrun_o
);

   localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [IW:0]   NREQ_W  = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ-1);

   typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

   state_t               state_q;
   logic [IW-1:0]        gnt_q;
   logic [IW-1:0]        rr_ptr_q;
   logic [IW-1:0]        rr_ptr_d;
   logic [1:0]           wait_q;
   logic                 map_rd_en_q;
   logic [9:0]           map_col_q;
   logic [9:0]           map_row_q;
   logic [NUM_REQ-1:0]   resp_valid_q;
   logic [3:0]           resp_dirs_q;
   logic                 resp_oob_q;
   logic [TW-1:0]        tick_cnt_q;
   logic                 tick_overrun_q;

   logic                 win_vld;
   logic [IW-1:0]        win_id;
   logic [IW:0]          idx_sum;
   logic [IW-1:0]        idx;
   logic [9:0]           win_x;
   logic [9:0]           win_y;
   logic [10:0]          col_sum;
   logic [10:0]          row_sum;
   logic                 win_oob;
   logic [NUM_REQ-1:0]   win_oh;
   logic [NUM_REQ-1:0]   gnt_oh;

   // Pick the winner: first set req bit at or above rr_ptr, wrapping; pacman may jump the queue.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx_sum = '0;
      idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
         if (idx_sum >= NREQ_W) begin
            idx_sum = idx_sum - NREQ_W;
         end
         idx = idx_sum[IW-1:0];
         if (!win_vld && req_i[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
`ifdef PACMAN_PRIORITY_EN
      if (req_i[0]) begin
         win_vld = 1'b1;
         win_id  = '0;
      end
`endif
   end

   // Winner coordinates, offset into map space with one spare bit so overflow reads as out of bounds.
   always_comb begin
      win_x = '0;
      win_y = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IW'(i) == win_id) begin
            win_x = req_x_i[10*i +: 10];
            win_y = req_y_i[10*i +: 10];
         end
      end
      col_sum = {1'b0, win_x} + 11'(XOFFSET);
      row_sum = {1'b0, win_y} + 11'(YOFFSET);
      win_oob = (col_sum >= 11'(MAP_W)) || (row_sum >= 11'(MAP_H));
      win_oh  = NUM_REQ'(1) << win_id;
      gnt_oh  = NUM_REQ'(1) << gnt_q;
   end

   // Round-robin pointer moves past the served requester; pacman grants leave it alone when prioritised.
   always_comb begin
      rr_ptr_d = (gnt_q == LAST_ID) ? '0 : gnt_q + IW'(1);
`ifdef PACMAN_PRIORITY_EN
      if (gnt_q == '0) begin
         rr_ptr_d = rr_ptr_q;
      end
`endif
   end

   // Lookup FSM with registered map strobe/address and response outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         rr_ptr_q     <= '0;
         wait_q       <= '0;
         map_rd_en_q  <= 1'b0;
         map_col_q    <= '0;
         map_row_q    <= '0;
         resp_valid_q <= '0;
         resp_dirs_q  <= '0;
         resp_oob_q   <= 1'b0;
      end else begin
         map_rd_en_q  <= 1'b0;
         resp_valid_q <= '0;
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  gnt_q <= win_id;
                  if (win_oob) begin
                     resp_valid_q <= win_oh;
                     resp_dirs_q  <= 4'b0000;
                     resp_oob_q   <= 1'b1;
                     state_q      <= RESP;
                  end else begin
                     map_col_q   <= col_sum[9:0];
                     map_row_q   <= row_sum[9:0];
                     map_rd_en_q <= 1'b1;
                     state_q     <= READ;
                  end
               end
            end
            READ: begin
               wait_q  <= 2'(RD_LAT-1);
               state_q <= WAIT;
            end
            WAIT: begin
               if (wait_q == 2'd0) begin
                  resp_dirs_q  <= map_data_i;
                  resp_oob_q   <= 1'b0;
                  resp_valid_q <= gnt_oh;
                  state_q      <= RESP;
               end else begin
                  wait_q <= wait_q - 2'd1;
               end
            end
            RESP: begin
               rr_ptr_q    <= rr_ptr_d;
               resp_dirs_q <= '0;
               resp_oob_q  <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign move_tick_o = (tick_cnt_q == TW'(TICK_DIV-1));

   // Free-running move tick divider and sticky overrun flag, independent of the lookup FSM.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_cnt_q     <= '0;
         tick_overrun_q <= 1'b0;
      end else begin
         tick_cnt_q <= move_tick_o ? '0 : tick_cnt_q + TW'(1);
         if (move_tick_o && ((req_i != '0) || (state_q != IDLE))) begin
            tick_overrun_q <= 1'b1;
         end
      end
   end

   assign map_rd_en_o    = map_rd_en_q;
   assign map_col_o      = map_col_q;
   assign map_row_o      = map_row_q;
   assign resp_valid_o   = resp_valid_q;
   assign resp_dirs_o    = resp_dirs_q;
   assign resp_oob_o     = resp_oob_q;
   assign tick_overrun_o = tick_overrun_q;

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Purpose: randomized and directed bench for maze_lookup_arbiter against a transaction-level model.
// Latency: bench runs with RD_LAT=3 and TICK_DIV=20 so both the read wait and the tick wrap are exercised.
// Backpressure: bench requesters hold req until their own response, as real movers do.
module tb_maze_lookup_arbiter;

   localparam int N  = 5;
   localparam int XO = 24;
   localparam int YO = 130;
   localparam int MW = 380;
   localparam int MH = 432;
   localparam int RL = 3;
   localparam int TD = 20;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req;
   logic [10*N-1:0]   req_x;
   logic [10*N-1:0]   req_y;
   logic              map_rd_en;
   logic [9:0]        map_col;
   logic [9:0]        map_row;
   logic [3:0]        map_data;
   logic [N-1:0]      resp_valid;
   logic [3:0]        resp_dirs;
   logic              resp_oob;
   logic              move_tick;
   logic              tick_overrun;

   always #5 clk = ~clk;

   maze_lookup_arbiter #(
      .NUM_REQ(N), .XOFFSET(XO), .YOFFSET(YO), .MAP_W(MW), .MAP_H(MH),
      .RD_LAT(RL), .TICK_DIV(TD)
   ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_x_i(req_x), .req_y_i(req_y),
      .map_rd_en_o(map_rd_en), .map_col_o(map_col), .map_row_o(map_row),
      .map_data_i(map_data), .resp_valid_o(resp_valid), .resp_dirs_o(resp_dirs),
      .resp_oob_o(resp_oob), .move_tick_o(move_tick), .tick_overrun_o(tick_overrun)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
   endtask

   // Map contents: one fixed cell from the directed case, a hash everywhere else.
   function automatic logic [3:0] map_fn(input int c, input int r);
      if (c == 124 && r == 180) return 4'b0101;
      return 4'(c * 7 + r * 3 + (c >> 3));
   endfunction

   // Map ROM: data valid only in the RL-th cycle after the read strobe, garbage otherwise.
   int rom_age = 0;
   int rom_col = 0;
   int rom_row = 0;
   always @(posedge clk) begin
      if (!rst_n) rom_age = 0;
      else if (map_rd_en) begin
         rom_age = 1;
         rom_col = int'(map_col);
         rom_row = int'(map_row);
      end else if (rom_age != 0) rom_age = (rom_age >= RL) ? 0 : rom_age + 1;
      #1;
      map_data = (rom_age == RL) ? map_fn(rom_col, rom_row) : 4'($urandom);
   end

   // Reference model state.
   int rr_m     = 0;
   bit busy_m   = 1'b0;
   int last_col = 0;
   int last_row = 0;
   int n_cyc    = 0;
   bit ovr_m    = 1'b0;

   function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef PACMAN_PRIORITY_EN
      if (r[0]) return 0;
`endif
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic int next_rr(input int win, input int ptr);
`ifdef PACMAN_PRIORITY_EN
      if (win == 0) return ptr;
`endif
      return (win + 1) % N;
   endfunction

   // Tick model: counts clock edges out of reset; overrun if anything was pending in a tick cycle.
   always @(posedge clk) begin
      if (!rst_n) begin
         n_cyc = 0;
         ovr_m = 1'b0;
      end else begin
         if ((n_cyc % TD) == TD - 1 && (req != '0 || busy_m)) ovr_m = 1'b1;
         n_cyc++;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk_eq("move_tick", 32'(move_tick), 32'((n_cyc % TD) == TD - 1));
         chk_eq("tick_overrun", 32'(tick_overrun), 32'(ovr_m));
      end
   end

   task automatic rand_coords(input int i);
      if ($urandom_range(3, 0) != 0) begin
         req_x[10*i +: 10] = 10'($urandom_range(MW - XO - 1, 0));
         req_y[10*i +: 10] = 10'($urandom_range(MH - YO - 1, 0));
      end else begin
         req_x[10*i +: 10] = 10'($urandom_range(1023, 0));
         req_y[10*i +: 10] = 10'($urandom_range(1023, 0));
      end
   endtask

   // One lookup, called #1 after an edge in an IDLE cycle with req already set up.
   task automatic do_txn(input bit hold, output int win);
      int col, row, lat;
      bit oob;
      win = pick(req, rr_m);
      if (win < 0) begin
         @(posedge clk); #1;
         chk_eq("idle_resp", 32'(resp_valid), 0);
         chk_eq("idle_rd_en", 32'(map_rd_en), 0);
         return;
      end
      col = int'(req_x[10*win +: 10]) + XO;
      row = int'(req_y[10*win +: 10]) + YO;
      oob = (col >= MW) || (row >= MH);
      lat = oob ? 1 : RL + 2;
      @(posedge clk); #1;
      busy_m = 1'b1;
      if (!oob) begin
         last_col = col;
         last_row = row;
      end
      if ($urandom_range(1, 0) == 1) begin
         req_x[10*win +: 10] = 10'($urandom);
         req_y[10*win +: 10] = 10'($urandom);
      end
      if (!hold && $urandom_range(3, 0) == 0) req[win] = 1'b0;
      for (int c = 1; c <= lat; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         chk_eq("rd_en", 32'(map_rd_en), 32'(c == 1 && !oob));
         chk_eq("resp_valid", 32'(resp_valid), (c == lat) ? (32'd1 << win) : 32'd0);
         if (c == 1 && !oob) begin
            chk_eq("rd_col", 32'(map_col), 32'(col));
            chk_eq("rd_row", 32'(map_row), 32'(row));
         end
      end
      chk_eq("hold_col", 32'(map_col), 32'(last_col));
      chk_eq("hold_row", 32'(map_row), 32'(last_row));
      chk_eq("dirs", 32'(resp_dirs), oob ? 32'd0 : 32'(map_fn(col, row)));
      chk_eq("oob", 32'(resp_oob), 32'(oob));
      if (!hold) req[win] = 1'b0;
      rr_m = next_rr(win, rr_m);
      @(posedge clk); #1;
      busy_m = 1'b0;
      chk_eq("resp_clr", 32'(resp_valid), 0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      req      = '0;
      rr_m     = 0;
      busy_m   = 1'b0;
      last_col = 0;
      last_row = 0;
      #1;
      chk_eq("rst_resp_valid", 32'(resp_valid), 0);
      chk_eq("rst_rd_en", 32'(map_rd_en), 0);
      chk_eq("rst_col", 32'(map_col), 0);
      chk_eq("rst_row", 32'(map_row), 0);
      chk_eq("rst_overrun", 32'(tick_overrun), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         chk_eq("quiet_resp", 32'(resp_valid), 0);
      end
   endtask

   initial begin
      int w;
      req = '0; req_x = '0; req_y = '0; map_data = '0; rst_n = 1'b0;
      #2;
      chk_eq("init_resp_valid", 32'(resp_valid), 0);
      chk_eq("init_dirs", 32'(resp_dirs), 0);
      chk_eq("init_oob", 32'(resp_oob), 0);
      chk_eq("init_tick", 32'(move_tick), 0);
      chk_eq("init_overrun", 32'(tick_overrun), 0);
      chk_eq("init_rd_en", 32'(map_rd_en), 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Single in-bounds lookup: col 124, row 180, mask 0101.
      req_x[9:0] = 10'd100; req_y[9:0] = 10'd50; req = 5'b00001;
      do_txn(1'b0, w);

      // All requesters held continuously: each served in turn.
      for (int i = 0; i < N; i++) begin
         req_x[10*i +: 10] = 10'($urandom_range(MW - XO - 1, 0));
         req_y[10*i +: 10] = 10'($urandom_range(MH - YO - 1, 0));
      end
      req = '1;
      for (int k = 0; k < N + 1; k++) do_txn(1'b1, w);
      req = '0;
      idle_cycles(2);

      // Out-of-bounds column.
      req_x[29:20] = 10'd360; req_y[29:20] = 10'd50; req = 5'b00100;
      do_txn(1'b0, w);

      // Random traffic with in-bounds and out-of-bounds coordinates.
      for (int t = 0; t < 300; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(2, 0) == 0) begin
               req[i] = 1'b1;
               rand_coords(i);
            end else if (req[i] && $urandom_range(9, 0) == 0) begin
               req[i] = 1'b0;
            end
         end
         do_txn(1'b0, w);
      end

      // Tick overrun: quiet through a tick, then a held request across one.
      do_reset();
      idle_cycles(TD + 5);
      chk_eq("ovr_quiet", 32'(tick_overrun), 0);
      req_x[19:10] = 10'd10; req_y[19:10] = 10'd10; req = 5'b00010;
      for (int k = 0; k < 6; k++) do_txn(1'b1, w);
      chk_eq("ovr_set", 32'(tick_overrun), 1);
      req = '0;
      idle_cycles(TD + 10);
      chk_eq("ovr_sticky", 32'(tick_overrun), 1);

      // Reset in the middle of a read wait aborts the lookup.
      do_reset();
      req_x[39:30] = 10'd20; req_y[39:30] = 10'd20; req = 5'b01000;
      do_txn(1'b0, w);
      req_x[29:20] = 10'd30; req_y[29:20] = 10'd30; req = 5'b00100;
      @(posedge clk); #1;
      busy_m = 1'b1;
      @(posedge clk); #1;
      do_reset();
      idle_cycles(RL + 3);
      for (int i = 1; i < N; i++) begin
         req_x[10*i +: 10] = 10'(40 + i); req_y[10*i +: 10] = 10'(60 + i);
      end
      req = 5'b11110;
      do_txn(1'b0, w);
      req = '0;

      // Pacman raised while ghosts are waiting.
      req_x[9:0] = 10'd5; req_y[9:0] = 10'd5;
      req = 5'b11000;
      do_txn(1'b0, w);
      req[0] = 1'b1;
      do_txn(1'b0, w);
      do_txn(1'b0, w);
      do_txn(1'b0, w);
      idle_cycles(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/maze_lookup_arbiter.md
Name: maze_lookup_arbiter

Overview:
- Shares the single read port of the maze intersection map among several movers: pacman (requester 0) and the ghosts (requesters 1..NUM_REQ-1).
- Each mover asks "which directions are open at (x,y)?" and gets a 4-bit {down,right,up,left} mask back (bit0 = left).
- Also generates the global move tick that paces all movers, and flags ticks where lookups overran.
- Sits between the mover FSMs and the map ROM in the game top level.

Parameters:
NUM_REQ, 5, number of requesters (2..8)
XOFFSET, 24, added to req x before map addressing
YOFFSET, 130, added to req y before map addressing
MAP_W, 380, map width; valid column index 0..MAP_W-1
MAP_H, 432, map height; valid row index 0..MAP_H-1
RD_LAT, 1, map read latency in cycles (1..4)
TICK_DIV, 1000000, clk cycles per move tick (>= 4*NUM_REQ)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  lookup request per requester, level, held until own resp_valid bit
req_x  in  10*NUM_REQ  packed x coordinates, requester i at bits [10i+9:10i]
req_y  in  10*NUM_REQ  packed y coordinates, same packing
map_rd_en  out  1  map read strobe, one cycle per lookup
map_col  out  10  map column = x+XOFFSET
map_row  out  10  map row = y+YOFFSET
map_data  in  4  direction mask, valid RD_LAT cycles after map_rd_en
resp_valid  out  NUM_REQ  one-hot, one-cycle pulse to the served requester
resp_dirs  out  4  direction mask, valid while any resp_valid bit is high
resp_oob  out  1  response was out of bounds (mask forced 0000)
move_tick  out  1  one-cycle pulse every TICK_DIV cycles
tick_overrun  out  1  sticky; set if any req was pending when move_tick fired

Behaviour:
- Reset (reset low, async): state IDLE, all outputs 0, rr_ptr=0, tick counter=0, tick_overrun=0.
- FSM states: IDLE, READ, WAIT, RESP.
- IDLE: if any req bit is high, the winner is the first set bit searching upward from rr_ptr, wrapping.
  - Register gnt id, col=x+XOFFSET and row=y+YOFFSET using 11-bit sums.
  - If col>=MAP_W or row>=MAP_H: go to RESP with dirs=0000 and oob=1; no map read.
  - Otherwise go to READ.
- READ: map_rd_en=1 for exactly this cycle; map_col/map_row hold the registered address. Go to WAIT, wait counter=RD_LAT-1.
- WAIT: count down. When the counter reaches 0, capture map_data at that edge and go to RESP.
- RESP: resp_valid[gnt]=1, resp_dirs and resp_oob valid for one cycle; rr_ptr=(gnt+1) mod NUM_REQ. Next state is IDLE.
- Latency from the edge sampling req: in-bounds RD_LAT+2 cycles to resp_valid; out-of-bounds 1 cycle.
- Throughput: one lookup in flight at a time; a new grant can occur no earlier than the cycle after RESP.
- req_x/req_y are sampled only at the grant edge; later changes do not affect the lookup in flight.
- A requester that drops req mid-lookup still receives its resp_valid pulse.
- Ungranted req bits that drop before grant are simply not served.
- The tick counter counts 0..TICK_DIV-1. move_tick=1 in the cycle the counter equals TICK_DIV-1, then it wraps to 0.
- The tick counter runs independently of the FSM.
- tick_overrun sets if req!=0 or the FSM is not IDLE in the move_tick cycle. Cleared only by reset.
- map_col/map_row hold their last value outside READ.
- Reset asserted mid-lookup aborts it: no resp_valid, FSM returns to IDLE.

Optional Feature:
PACMAN_PRIORITY_EN
- Defined: req[0] (pacman) wins in IDLE whenever set, regardless of rr_ptr. The remaining requesters share round-robin among themselves, and rr_ptr is not advanced by pacman grants.
- Undefined: pure round-robin across all NUM_REQ requesters.

Test Plan:
- Single request, RD_LAT=1: req=00001, x=100, y=50, map returns 0101 at col 124 row 180 → map_rd_en one cycle with col=124, row=180; resp_valid=00001 3 cycles after the req edge; resp_dirs=0101; resp_oob=0.
- Round-robin: req=11111 held continuously → grants in order 0,1,2,3,4,0, each with its own resp_valid pulse; no requester served twice before all others are served.
- Out of bounds: req=00100, x=360 (col 384>=380) → no map_rd_en; resp_valid=00100 next cycle; dirs=0000; resp_oob=1.
- Latency sweep with RD_LAT=3: map_data driven only on the 3rd cycle after map_rd_en → that exact value returned; dirs match.
- Tick/overrun with TICK_DIV=20: move_tick every 20 cycles; req held high across a tick → tick_overrun=1 and stays 1 until reset.
- Reset mid-WAIT: reset low for 1 cycle → resp_valid never pulses; FSM is IDLE; rr_ptr=0; the next req is served normally. Repeat with PACMAN_PRIORITY_EN defined and req=11000 then req[0] raised → grant 0 next.
